// File: rtl/gemm_issue_ctrl_pkg.sv
// Shared types and default sizing for the GEMM issue controller and its request FIFO.
// The optional weight-reuse feature is selected in the top level with GEMM_WEIGHT_REUSE_EN.
package gemm_issue_ctrl_pkg;

    localparam int REGW             = 4;
    localparam int NREGS            = 1 << REGW;
    localparam int DEPTH_DEF        = 4;
    localparam int WLOAD_CYCLES_DEF = 4;
    localparam int MAX_OUTST_DEF    = 4;

    typedef struct packed {
        logic            new_weight;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rs3;
        logic [REGW-1:0] rd;
    } gemm_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WLOAD = 2'd2
    } gemm_ictl_state_t;

endpackage

// File: rtl/gemm_req_fifo.sv
// Request FIFO for decoded GEMM ops: DEPTH entries (power of 2), synchronous reset,
// head entry read straight out of the storage registers.
module gemm_req_fifo
    import gemm_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  gemm_req_t                  wdata,
    input  logic                       pop,
    output gemm_req_t                  head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    gemm_req_t        mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because cnt decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; full is taken from the registered count, so a pop never frees a slot in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/gemm_issue_ctrl.sv
// In-order issue scheduler in front of fu_gemm: buffers ops, blocks RAW/WAW hazards with a
// writeback-cleared scoreboard, limits ops in flight and stalls while the array loads weights.
// Optional feature: define GEMM_WEIGHT_REUSE_EN to skip reloading weights already in the array.
module gemm_issue_ctrl
    import gemm_issue_ctrl_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int WLOAD_CYCLES = WLOAD_CYCLES_DEF,
    parameter int MAX_OUTST    = MAX_OUTST_DEF
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_new_weight,
    input  logic [REGW-1:0]                req_rs1,
    input  logic [REGW-1:0]                req_rs2,
    input  logic [REGW-1:0]                req_rs3,
    input  logic [REGW-1:0]                req_rd,
    input  logic                           array_ready,
    input  logic                           wb_valid,
    input  logic [REGW-1:0]                wb_rd,
    output logic                           gemm_enable,
    output logic                           new_weight_out,
    output logic [REGW-1:0]                rs1_out,
    output logic [REGW-1:0]                rs2_out,
    output logic [REGW-1:0]                rs3_out,
    output logic [REGW-1:0]                rd_out,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           busy
);

    localparam int OCW = $clog2(MAX_OUTST + 1);
    localparam int WLW = $clog2(WLOAD_CYCLES + 1);
    localparam int CW  = $clog2(DEPTH + 1);
    // The pulse cycle of the loading op is the first busy cycle, so the counter covers the remaining ones.
    localparam logic [WLW-1:0] WL_LOAD = WLW'(WLOAD_CYCLES - 1);

    gemm_ictl_state_t state;
    gemm_ictl_state_t state_next;

    gemm_req_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             push;

    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] sb_eff;
    logic [NREGS-1:0] wb_mask;
    logic             wb_hit;
    logic             hazard;
    logic             issue;
    logic             nw_eff;
    logic             load_weight;
    logic             will_have;
    logic [WLW-1:0]   wl_cnt;

    assign req_ready = !fifo_full;
    assign push      = req_valid && !fifo_full;
    assign wb_hit    = wb_valid && sb[wb_rd];
    assign busy      = !fifo_empty || (outst_cnt != '0) || (wl_cnt != '0);

    gemm_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .wdata ('{new_weight: req_new_weight, rs1: req_rs1, rs2: req_rs2, rs3: req_rs3, rd: req_rd}),
        .pop   (issue),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef GEMM_WEIGHT_REUSE_EN
    logic [REGW-1:0] last_w_reg;
    logic            last_w_valid;

    assign nw_eff = head.new_weight && !(last_w_valid && (head.rs2 == last_w_reg));

    // Remember which register the array's weights came from; overwriting that register invalidates it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_w_reg   <= '0;
            last_w_valid <= 1'b0;
        end else if (issue) begin
            if (nw_eff) begin
                last_w_reg   <= head.rs2;
                last_w_valid <= (head.rd != head.rs2);
            end else if (head.rd == last_w_reg) begin
                last_w_valid <= 1'b0;
            end
        end
    end
`else
    assign nw_eff = head.new_weight;
`endif

    // Hazard check: a writeback arriving this cycle already releases its register.
    always_comb begin
        wb_mask = '0;
        if (wb_hit) begin
            wb_mask[wb_rd] = 1'b1;
        end
        sb_eff = sb & ~wb_mask;
        hazard = sb_eff[head.rs1] || sb_eff[head.rs2] || sb_eff[head.rs3] || sb_eff[head.rd];
    end

    // Issue decision and next FSM state; a head arriving while IDLE may issue in its first cycle.
    always_comb begin
        issue       = 1'b0;
        load_weight = 1'b0;
        state_next  = state;
        if (!fifo_empty && (state != WLOAD) && (wl_cnt == '0) && array_ready &&
            (outst_cnt < OCW'(MAX_OUTST)) && !hazard) begin
            issue = 1'b1;
        end
        if (issue && nw_eff && (WL_LOAD != '0)) begin
            load_weight = 1'b1;
        end
        will_have = push || (fifo_count > CW'(1)) || ((fifo_count == CW'(1)) && !issue);
        if (load_weight) begin
            state_next = WLOAD;
        end else if (wl_cnt > WLW'(1)) begin
            state_next = WLOAD;
        end else if (will_have) begin
            state_next = RUN;
        end else begin
            state_next = IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Weight-load countdown; issue stays blocked until it reaches zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wl_cnt <= '0;
        end else if (load_weight) begin
            wl_cnt <= WL_LOAD;
        end else if (wl_cnt != '0) begin
            wl_cnt <= wl_cnt - 1'b1;
        end
    end

    // Scoreboard: the set from an issue is written last so it wins over a same-cycle clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sb <= '0;
        end else begin
            if (wb_hit) begin
                sb[wb_rd] <= 1'b0;
            end
            if (issue) begin
                sb[head.rd] <= 1'b1;
            end
        end
    end

    // In-flight count tracks the number of set scoreboard bits, so it cannot wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            outst_cnt <= '0;
        end else begin
            case ({issue, wb_hit})
                2'b10:   outst_cnt <= outst_cnt + 1'b1;
                2'b01:   outst_cnt <= outst_cnt - 1'b1;
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

    // Registered issue outputs; operands are zeroed whenever nothing issues.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gemm_enable    <= 1'b0;
            new_weight_out <= 1'b0;
            rs1_out        <= '0;
            rs2_out        <= '0;
            rs3_out        <= '0;
            rd_out         <= '0;
        end else begin
            gemm_enable    <= issue;
            new_weight_out <= issue && nw_eff;
            rs1_out        <= issue ? head.rs1 : '0;
            rs2_out        <= issue ? head.rs2 : '0;
            rs3_out        <= issue ? head.rs3 : '0;
            rd_out         <= issue ? head.rd  : '0;
        end
    end

endmodule

// File: tb/tb_gemm_issue_ctrl.sv
// Self-checking bench for gemm_issue_ctrl: directed scenarios plus randomized traffic
// compared against a queue/set based reference model of the issue rules.
module tb_gemm_issue_ctrl;
    import gemm_issue_ctrl_pkg::*;

    localparam int W    = WLOAD_CYCLES_DEF;
    localparam int MAXO = MAX_OUTST_DEF;
    localparam int DEP  = DEPTH_DEF;
    localparam int OCW  = $clog2(MAXO + 1);

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_new_weight = 1'b0;
    logic [3:0]     req_rs1 = '0, req_rs2 = '0, req_rs3 = '0, req_rd = '0;
    logic           array_ready = 1'b0;
    logic           wb_valid = 1'b0;
    logic [3:0]     wb_rd = '0;
    logic           gemm_enable, new_weight_out, busy;
    logic [3:0]     rs1_out, rs2_out, rs3_out, rd_out;
    logic [OCW-1:0] outst_cnt;

    gemm_issue_ctrl dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_new_weight(req_new_weight), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_rs3(req_rs3), .req_rd(req_rd), .array_ready(array_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .gemm_enable(gemm_enable),
        .new_weight_out(new_weight_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
        .rs3_out(rs3_out), .rd_out(rd_out), .outst_cnt(outst_cnt), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_failed = 0;

    typedef struct {
        bit         nw;
        logic [3:0] rs1, rs2, rs3, rd;
    } op_t;

    // Reference model state: pending ops, registers awaiting writeback, in-flight count,
    // the first edge at which the array is free again, and the register holding loaded weights.
    op_t        mq[$];
    bit         m_sb[16];
    int         m_outst = 0;
    int         m_cyc = 0;
    int         m_free_at = 0;
    bit         m_lw_valid = 0;
    logic [3:0] m_lw_reg = '0;

    bit         e_en, e_nw, e_ready, e_busy;
    logic [3:0] e_rs1, e_rs2, e_rs3, e_rd;
    int         e_outst;

    function automatic bit reg_busy(logic [3:0] r, bit wb_clr);
        return m_sb[r] && !(wb_clr && (r == wb_rd));
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        op_t h;
        bit  wb_clr, iss, acc, nwo;
        int  pre_size;
        m_cyc++;
        if (RST) begin
            mq.delete();
            foreach (m_sb[i]) m_sb[i] = 0;
            m_outst = 0; m_free_at = 0; m_lw_valid = 0;
            e_en = 0; e_nw = 0; e_rs1 = 0; e_rs2 = 0; e_rs3 = 0; e_rd = 0;
            e_ready = 1; e_busy = 0; e_outst = 0;
            return;
        end
        pre_size = mq.size();
        acc = req_valid && (pre_size < DEP);
        wb_clr = wb_valid && m_sb[wb_rd];
        iss = 0;
        nwo = 0;
        h = '{0, 0, 0, 0, 0};
        if (pre_size > 0 && array_ready && m_cyc >= m_free_at && m_outst < MAXO) begin
            h = mq[0];
            iss = !(reg_busy(h.rs1, wb_clr) || reg_busy(h.rs2, wb_clr) ||
                    reg_busy(h.rs3, wb_clr) || reg_busy(h.rd, wb_clr));
        end
        if (iss) begin
            void'(mq.pop_front());
            nwo = h.nw;
`ifdef GEMM_WEIGHT_REUSE_EN
            if (h.nw && m_lw_valid && h.rs2 == m_lw_reg) nwo = 0;
            if (nwo) begin
                m_lw_reg = h.rs2;
                m_lw_valid = (h.rd != h.rs2);
            end else if (h.rd == m_lw_reg) begin
                m_lw_valid = 0;
            end
`endif
            if (nwo) m_free_at = m_cyc + W;
        end
        if (wb_clr) begin m_sb[wb_rd] = 0; m_outst--; end
        if (iss)    begin m_sb[h.rd] = 1;  m_outst++; end
        if (acc) mq.push_back('{req_new_weight, req_rs1, req_rs2, req_rs3, req_rd});
        e_en = iss; e_nw = nwo;
        e_rs1 = iss ? h.rs1 : 4'd0; e_rs2 = iss ? h.rs2 : 4'd0;
        e_rs3 = iss ? h.rs3 : 4'd0; e_rd  = iss ? h.rd  : 4'd0;
        e_ready = (mq.size() < DEP);
        e_outst = m_outst;
        e_busy = (mq.size() != 0) || (m_outst != 0) || (m_cyc < m_free_at - 1);
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_op(input bit nw, input logic [3:0] a, b, c, d);
        req_valid = 1; req_new_weight = nw;
        req_rs1 = a; req_rs2 = b; req_rs3 = c; req_rd = d;
    endtask

    task automatic apply_reset();
        RST = 1; req_valid = 0; wb_valid = 0;
        tick();
        RST = 0;
    endtask

    task automatic test_reset();
        RST = 1; req_valid = 1; array_ready = 1;
        tick(); tick();
        n_tests++;
        if ({gemm_enable, new_weight_out, rs1_out, rs2_out, rs3_out, rd_out, outst_cnt, busy} !== '0) begin
            n_failed++;
            $display("[TB] FAIL reset_outputs: en=%b nw=%b rs=%h/%h/%h rd=%h outst=%0d busy=%b, expected all 0",
                     gemm_enable, new_weight_out, rs1_out, rs2_out, rs3_out, rd_out, outst_cnt, busy);
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL reset_ready: req_ready=%b expected 1", req_ready);
        end
        RST = 0; req_valid = 0;
    endtask

    task automatic test_single_op();
        apply_reset();
        array_ready = 1;
        drive_op(0, 1, 2, 3, 4);
        tick();
        req_valid = 0;
        n_tests++;
        if (gemm_enable !== 1'b0 || busy !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL single_enqueue: en=%b busy=%b expected en=0 busy=1", gemm_enable, busy);
        end
        tick();
        n_tests++;
        if ({gemm_enable, new_weight_out, rs1_out, rs2_out, rs3_out, rd_out} !== {1'b1, 1'b0, 4'd1, 4'd2, 4'd3, 4'd4}) begin
            n_failed++;
            $display("[TB] FAIL single_issue: en=%b nw=%b rs=%h/%h/%h rd=%h expected 1 0 1/2/3 4",
                     gemm_enable, new_weight_out, rs1_out, rs2_out, rs3_out, rd_out);
        end
        n_tests++;
        if (outst_cnt !== OCW'(1)) begin
            n_failed++;
            $display("[TB] FAIL single_outst: outst_cnt=%0d expected 1", outst_cnt);
        end
        tick();
        n_tests++;
        if (gemm_enable !== 1'b0 || rd_out !== 4'd0) begin
            n_failed++;
            $display("[TB] FAIL single_pulse: en=%b rd=%h expected 0 0", gemm_enable, rd_out);
        end
        wb_valid = 1; wb_rd = 4;
        tick();
        wb_valid = 0;
        n_tests++;
        if (outst_cnt !== '0 || busy !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL single_wb: outst_cnt=%0d busy=%b expected 0 0", outst_cnt, busy);
        end
    endtask

    task automatic test_weight_load();
        int  t_a = -1, t_b = -1;
        bit  nw_a = 0, nw_b = 1;
        apply_reset();
        array_ready = 1;
        drive_op(1, 1, 2, 3, 8); tick();
        drive_op(0, 1, 2, 3, 9); tick();
        req_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (gemm_enable === 1'b1 && rd_out === 4'd8) begin t_a = i; nw_a = new_weight_out; end
            if (gemm_enable === 1'b1 && rd_out === 4'd9) begin t_b = i; nw_b = new_weight_out; end
            tick();
        end
        n_tests++;
        if (t_a < 0 || t_b < 0 || (t_b - t_a) != W) begin
            n_failed++;
            $display("[TB] FAIL wload_gap: A at %0d B at %0d expected gap %0d", t_a, t_b, W);
        end
        n_tests++;
        if (nw_a !== 1'b1 || nw_b !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL wload_flag: new_weight_out A=%b B=%b expected 1 0", nw_a, nw_b);
        end
    endtask

    task automatic test_raw();
        int early = 0;
        apply_reset();
        array_ready = 1;
        drive_op(0, 1, 2, 3, 5);  tick();
        drive_op(0, 5, 2, 3, 10); tick();
        req_valid = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (gemm_enable === 1'b1) early++;
        end
        n_tests++;
        if (early != 0) begin
            n_failed++;
            $display("[TB] FAIL raw_hold: %0d issues before writeback expected 0", early);
        end
        wb_valid = 1; wb_rd = 6;
        tick();
        n_tests++;
        if (gemm_enable !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL raw_wrong_wb: en=%b expected 0", gemm_enable);
        end
        wb_rd = 5;
        tick();
        wb_valid = 0;
        n_tests++;
        if (gemm_enable !== 1'b1 || rs1_out !== 4'd5 || rd_out !== 4'd10 || outst_cnt !== OCW'(1)) begin
            n_failed++;
            $display("[TB] FAIL raw_release: en=%b rs1=%h rd=%h outst=%0d expected 1 5 a 1",
                     gemm_enable, rs1_out, rd_out, outst_cnt);
        end
    endtask

    task automatic test_full_limit();
        int  idx = 0, pulses = 0;
        bit  rdy;
        apply_reset();
        array_ready = 0;
        for (int i = 0; i < 6; i++) begin
            drive_op(0, 0, 0, 0, 4'(idx + 1));
            rdy = req_ready;
            tick();
            if (rdy) idx++;
            if (gemm_enable === 1'b1) pulses++;
        end
        n_tests++;
        if (idx != 4 || req_ready !== 1'b0 || pulses != 0) begin
            n_failed++;
            $display("[TB] FAIL full_accept: accepted=%0d ready=%b pulses=%0d expected 4 0 0", idx, req_ready, pulses);
        end
        array_ready = 1;
        for (int i = 0; i < 16; i++) begin
            if (idx < 6) drive_op(0, 0, 0, 0, 4'(idx + 1));
            else req_valid = 0;
            rdy = req_ready;
            tick();
            if (rdy && idx < 6) idx++;
            if (gemm_enable === 1'b1) pulses++;
        end
        req_valid = 0;
        n_tests++;
        if (pulses != 4 || outst_cnt !== OCW'(4) || idx != 6) begin
            n_failed++;
            $display("[TB] FAIL outst_limit: pulses=%0d outst=%0d accepted=%0d expected 4 4 6", pulses, outst_cnt, idx);
        end
        n_tests++;
        if (busy !== 1'b1 || req_ready !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL limit_status: busy=%b ready=%b expected 1 1", busy, req_ready);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        array_ready = 1;
        drive_op(0, 1, 2, 3, 7); tick();
        drive_op(0, 1, 2, 3, 7); tick();
        req_valid = 0;
        tick(); tick(); tick();
        n_tests++;
        if (gemm_enable !== 1'b0 || outst_cnt !== OCW'(1)) begin
            n_failed++;
            $display("[TB] FAIL waw_hold: en=%b outst=%0d expected 0 1", gemm_enable, outst_cnt);
        end
        wb_valid = 1; wb_rd = 7;
        tick();
        wb_valid = 0;
        n_tests++;
        if (gemm_enable !== 1'b1 || rd_out !== 4'd7 || outst_cnt !== OCW'(1)) begin
            n_failed++;
            $display("[TB] FAIL same_cycle_set_clear: en=%b rd=%h outst=%0d expected 1 7 1", gemm_enable, rd_out, outst_cnt);
        end
        drive_op(0, 7, 0, 0, 11); tick();
        req_valid = 0;
        tick(); tick();
        n_tests++;
        if (gemm_enable !== 1'b0 || busy !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL sb_set_wins: en=%b busy=%b expected 0 1", gemm_enable, busy);
        end
        apply_reset();
        drive_op(1, 1, 2, 3, 8); tick();
        drive_op(0, 1, 2, 3, 9); tick();
        req_valid = 0;
        tick();
        RST = 1;
        tick();
        RST = 0;
        n_tests++;
        if ({gemm_enable, new_weight_out, rs1_out, rs2_out, rs3_out, rd_out, outst_cnt, busy} !== '0 || req_ready !== 1'b1) begin
            n_failed++;
            $display("[TB] FAIL reset_in_wload: en=%b outst=%0d busy=%b ready=%b expected 0 0 0 1",
                     gemm_enable, outst_cnt, busy, req_ready);
        end
        wb_valid = 1; wb_rd = 8;
        tick();
        wb_valid = 0;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (gemm_enable !== 1'b0 || outst_cnt !== '0 || busy !== 1'b0) begin
            n_failed++;
            $display("[TB] FAIL reset_discard: en=%b outst=%0d busy=%b expected 0 0 0", gemm_enable, outst_cnt, busy);
        end
    endtask

    task automatic test_reuse();
        op_t ops[3];
        int  t_a = -1, t_b = -1, t_c = -1;
        bit  nw_b = 0;
        bit  exp_nw_b;
        int  exp_gap_c;
        ops[0] = '{1, 1, 2, 3, 8};
        ops[1] = '{1, 4, 2, 5, 9};
        ops[2] = '{0, 4, 5, 6, 10};
`ifdef GEMM_WEIGHT_REUSE_EN
        exp_nw_b = 0; exp_gap_c = 1;
`else
        exp_nw_b = 1; exp_gap_c = W;
`endif
        apply_reset();
        array_ready = 1;
        for (int i = 0; i < 30; i++) begin
            if (i < 3) drive_op(ops[i].nw, ops[i].rs1, ops[i].rs2, ops[i].rs3, ops[i].rd);
            else req_valid = 0;
            tick();
            if (gemm_enable === 1'b1 && rd_out === 4'd8)  t_a = i;
            if (gemm_enable === 1'b1 && rd_out === 4'd9)  begin t_b = i; nw_b = new_weight_out; end
            if (gemm_enable === 1'b1 && rd_out === 4'd10) t_c = i;
        end
        n_tests++;
        if (t_a < 0 || t_b < 0 || (t_b - t_a) != W || nw_b !== exp_nw_b) begin
            n_failed++;
            $display("[TB] FAIL reuse_second: A at %0d B at %0d nw=%b expected gap %0d nw=%b", t_a, t_b, nw_b, W, exp_nw_b);
        end
        n_tests++;
        if (t_c < 0 || (t_c - t_b) != exp_gap_c) begin
            n_failed++;
            $display("[TB] FAIL reuse_follow: B at %0d C at %0d expected gap %0d", t_b, t_c, exp_gap_c);
        end
    endtask

    task automatic test_random();
        int             cand[$];
        logic [OCW-1:0] eo;
        apply_reset();
        for (int it = 0; it < 400; it++) begin
            RST = ($urandom_range(99) == 0);
            req_valid = $urandom_range(1);
            req_new_weight = ($urandom_range(3) == 0);
            req_rs1 = 4'($urandom_range(15)); req_rs2 = 4'($urandom_range(15));
            req_rs3 = 4'($urandom_range(15)); req_rd  = 4'($urandom_range(15));
            array_ready = ($urandom_range(3) != 0);
            wb_valid = ($urandom_range(2) == 0);
            cand.delete();
            for (int r = 0; r < 16; r++) if (m_sb[r]) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(3) != 0) wb_rd = 4'(cand[$urandom_range(cand.size() - 1)]);
            else wb_rd = 4'($urandom_range(15));
            tick();
            eo = OCW'(e_outst);
            n_tests++;
            if ({gemm_enable, new_weight_out, rs1_out, rs2_out, rs3_out, rd_out, req_ready, outst_cnt, busy} !==
                {e_en, e_nw, e_rs1, e_rs2, e_rs3, e_rd, e_ready, eo, e_busy}) begin
                n_failed++;
                $display("[TB] FAIL random_%0d: got en=%b nw=%b ops=%h%h%h%h rdy=%b outst=%0d busy=%b, expected en=%b nw=%b ops=%h%h%h%h rdy=%b outst=%0d busy=%b",
                         it, gemm_enable, new_weight_out, rs1_out, rs2_out, rs3_out, rd_out, req_ready, outst_cnt, busy,
                         e_en, e_nw, e_rs1, e_rs2, e_rs3, e_rd, e_ready, eo, e_busy);
            end
        end
        RST = 0; req_valid = 0; wb_valid = 0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_weight_load();
        test_raw();
        test_full_limit();
        test_simultaneous();
        test_reuse();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
